// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between the single master and the memory slave.
interface ahb_mem_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hready;
    logic                  hresp;

    modport master (
        output hsel, htrans, hwrite, hsize, haddr, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, htrans, hwrite, hsize, haddr, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: reads, sized writes, programmable wait states and a
// two-cycle ERROR response. Being the only slave, its hready is the bus hready.
module ahb_mem_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic hclk,
    input  logic hresetn,
    ahb_mem_slave_if.slave bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(NB);
    localparam int OFF_W = (LOG2B > 0) ? LOG2B : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Byte-lane enables for lanes [off, off + 2^size).
    function automatic logic [NB-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                input logic [2:0] size);
        logic [NB-1:0] m;
        int            lo;
        int            hi;
        lo = int'(off);
        hi = lo + (1 << int'(size));
        for (int i = 0; i < NB; i++) begin
            m[i] = (i >= lo) && (i < hi);
        end
        return m;
    endfunction

    // Replace the enabled byte lanes of old_w with those of new_w.
    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [NB-1:0]         mask);
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < NB; i++) begin
            res[i*8 +: 8] = mask[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return res;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_hready;
    logic                  r_hresp;
    logic [DATA_WIDTH-1:0] r_hrdata;

    // Data-phase copy of the accepted legal transfer.
    logic                  r_pend;
    logic                  r_pwrite;
    logic [IDX_W-1:0]      r_pidx;
    logic [OFF_W-1:0]      r_poff;
    logic [2:0]            r_psize;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_active;
    logic                  w_accept;
    logic                  w_legal;
    logic [ADDR_WIDTH-1:0] w_idx_full;
    logic [OFF_W-1:0]      w_off;
    logic                  w_commit;
    logic [NB-1:0]         w_wmask;
    logic                  w_rd_load;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_active   = bus.hsel && bus.htrans[1];
    assign w_accept   = r_hready && w_active;
    assign w_idx_full = bus.haddr >> LOG2B;
    assign w_off      = (LOG2B > 0) ? OFF_W'(bus.haddr) : '0;
    assign w_commit   = r_hready && r_pend && r_pwrite;
    assign w_wmask    = lane_mask(r_poff, r_psize);

    // Classify the address phase: out of range, oversize or misaligned is illegal.
    always_comb begin
        w_legal = 1'b1;
        if (int'(w_idx_full) >= DEPTH) begin
            w_legal = 1'b0;
        end else if (int'(bus.hsize) > LOG2B) begin
            w_legal = 1'b0;
        end else if ((int'(bus.haddr) & ((1 << int'(bus.hsize)) - 1)) != 0) begin
            w_legal = 1'b0;
        end else begin
            w_legal = 1'b1;
        end
    end

    // Next-state and wait-counter logic of the response FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (w_accept && !w_legal) begin
                    w_state_nxt = ST_ERR1;
                end else if (w_accept && (WAIT_STATES > 0)) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // FSM state, counter and registered handshake outputs.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ERR2);
            r_hresp  <= (w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2);
        end
    end

    // Latch address/control on every ready edge; hold it through wait cycles.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_pend   <= 1'b0;
            r_pwrite <= 1'b0;
            r_pidx   <= '0;
            r_poff   <= '0;
            r_psize  <= 3'd0;
        end else if (r_hready) begin
            r_pend   <= w_accept && w_legal;
            r_pwrite <= bus.hwrite;
            r_pidx   <= IDX_W'(w_idx_full);
            r_poff   <= w_off;
            r_psize  <= bus.hsize;
        end else begin
            r_pend   <= r_pend;
        end
    end

    // Commit the write lanes at the end of the write completion cycle.
    always_ff @(posedge hclk) begin
        if (w_commit) begin
            r_mem[r_pidx] <= merge(r_mem[r_pidx], bus.hwdata, w_wmask);
        end
    end

    // Pick the read word to load, forwarding a write committing on the same edge.
    always_comb begin
        w_rd_load = 1'b0;
        w_rd_idx  = r_pidx;
        if (WAIT_STATES == 0) begin
            w_rd_load = w_accept && w_legal && !bus.hwrite;
            w_rd_idx  = IDX_W'(w_idx_full);
        end else begin
            w_rd_load = (r_state == ST_WAIT) && (r_cnt == 4'd1) && r_pend && !r_pwrite;
            w_rd_idx  = r_pidx;
        end
        w_rd_word = r_mem[w_rd_idx];
        if (w_commit && (r_pidx == w_rd_idx)) begin
            w_rd_word = merge(w_rd_word, bus.hwdata, w_wmask);
        end else begin
            w_rd_word = r_mem[w_rd_idx];
        end
    end

    // Read data is non-zero only during a read completion cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_hrdata <= '0;
        end else if (w_rd_load) begin
            r_hrdata <= w_rd_word;
        end else begin
            r_hrdata <= '0;
        end
    end

    assign bus.hready = r_hready;
    assign bus.hresp  = r_hresp;
    assign bus.hrdata = r_hrdata;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: one zero-wait instance and one three-wait instance.
module tb_ahb_mem_slave;
    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NS   = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;

    logic hclk = 1'b0;
    logic hresetn = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;

    always #5 hclk = ~hclk;

    ahb_mem_slave_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus0 ();
    ahb_mem_slave_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus3 ();

    ahb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .bus(bus0.slave));
    ahb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hresetn(hresetn), .bus(bus3.slave));

    task automatic addr0(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [9:0] a);
        bus0.hsel = sel; bus0.htrans = tr; bus0.hwrite = wr; bus0.hsize = sz; bus0.haddr = a;
    endtask

    task automatic addr3(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [9:0] a);
        bus3.hsel = sel; bus3.htrans = tr; bus3.hwrite = wr; bus3.hsize = sz; bus3.haddr = a;
    endtask

    // Full word write on the zero-wait slave; returns in its completion cycle.
    task automatic write0(input logic [9:0] a, input logic [31:0] d);
        @(negedge hclk); addr0(1'b1, T_NS, 1'b1, 3'd2, a);
        @(negedge hclk); addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = d;
    endtask

    // Full word write on the wait-state slave, bounded wait for completion.
    task automatic write3(input logic [9:0] a, input logic [31:0] d);
        int n;
        @(negedge hclk); addr3(1'b1, T_NS, 1'b1, 3'd2, a);
        @(negedge hclk); addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus3.hwdata = d;
        n = 0;
        while (bus3.hready !== 1'b1 && n < 20) begin n++; @(negedge hclk); end
        checks++;
        if (bus3.hready !== 1'b1) begin
            errors++; $display("FAIL write3_timeout: hready=%b required 1", bus3.hready);
        end
    endtask

    task automatic test_reset();
        addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = 32'h0;
        addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus3.hwdata = 32'h0;
        #2 hresetn = 1'b0;
        repeat (5) @(negedge hclk);
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL rst_hready0: got %b want 1", bus0.hready); end
        checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp0: got %b want 0", bus0.hresp); end
        checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata0: got %h want 0", bus0.hrdata); end
        checks++; if (bus3.hready !== 1'b1) begin errors++; $display("FAIL rst_hready3: got %b want 1", bus3.hready); end
        checks++; if (bus3.hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp3: got %b want 0", bus3.hresp); end
        checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata3: got %h want 0", bus3.hrdata); end
        hresetn = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge hclk); addr0(1'b1, T_NS, 1'b1, 3'd2, 10'h00C);
        @(negedge hclk); bus0.hwdata = 32'h5A5A5A5A; addr0(1'b1, T_NS, 1'b0, 3'd2, 10'h00C);
        exp_q.push_back(32'h5A5A5A5A);
        @(negedge hclk);
        exp_w = exp_q.pop_front();
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL raw_hready: got %b want 1", bus0.hready); end
        checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL raw_hresp: got %b want 0", bus0.hresp); end
        checks++; if (bus0.hrdata !== exp_w) begin errors++; $display("FAIL raw_hrdata: got %h want %h", bus0.hrdata, exp_w); end
        addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = 32'h0;
        @(negedge hclk);
        checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("FAIL raw_hrdata_idle: got %h want 0", bus0.hrdata); end
    endtask

    task automatic test_byte_lanes();
        @(negedge hclk); addr0(1'b1, T_NS, 1'b1, 3'd2, 10'h010);
        @(negedge hclk); bus0.hwdata = 32'h11223344; addr0(1'b1, T_NS, 1'b1, 3'd0, 10'h013);
        @(negedge hclk); bus0.hwdata = 32'hAA000000; addr0(1'b1, T_NS, 1'b0, 3'd2, 10'h010);
        exp_q.push_back(32'hAA223344);
        @(negedge hclk);
        exp_w = exp_q.pop_front();
        checks++; if (bus0.hrdata !== exp_w) begin errors++; $display("FAIL byte_lane: got %h want %h", bus0.hrdata, exp_w); end
        checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL byte_lane_hresp: got %b want 0", bus0.hresp); end
        bus0.hwdata = 32'h0; addr0(1'b1, T_NS, 1'b1, 3'd1, 10'h010);
        @(negedge hclk); bus0.hwdata = 32'h0000CAFE; addr0(1'b1, T_NS, 1'b0, 3'd1, 10'h012);
        exp_q.push_back(32'hAA22CAFE);
        @(negedge hclk);
        exp_w = exp_q.pop_front();
        checks++; if (bus0.hrdata !== exp_w) begin errors++; $display("FAIL half_lane: got %h want %h", bus0.hrdata, exp_w); end
        addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = 32'h0;
    endtask

    task automatic test_wait_states();
        int lows;
        @(negedge hclk); addr3(1'b1, T_NS, 1'b1, 3'd2, 10'h020);
        @(negedge hclk); addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus3.hwdata = 32'hDEADBEEF;
        lows = 0;
        while (bus3.hready !== 1'b1 && lows < 20) begin lows++; @(negedge hclk); end
        checks++; if (lows != 3) begin errors++; $display("FAIL ws_write_waits: got %0d want 3", lows); end
        // Read issued in the write's completion cycle (pipelined).
        addr3(1'b1, T_NS, 1'b0, 3'd2, 10'h020);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge hclk);
        checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL ws_hrdata_wait: got %h want 0", bus3.hrdata); end
        lows = 0;
        while (bus3.hready !== 1'b1 && lows < 20) begin
            lows++;
            addr3(1'b1, T_NS, 1'b0, 3'd2, 10'(10'h024 + 10'(lows * 4)));
            @(negedge hclk);
        end
        exp_w = exp_q.pop_front();
        checks++; if (lows != 3) begin errors++; $display("FAIL ws_read_waits: got %0d want 3", lows); end
        checks++; if (bus3.hrdata !== exp_w) begin errors++; $display("FAIL ws_read_data: got %h want %h", bus3.hrdata, exp_w); end
        checks++; if (bus3.hresp !== 1'b0) begin errors++; $display("FAIL ws_read_hresp: got %b want 0", bus3.hresp); end
        addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000);
        @(negedge hclk);
        checks++; if (bus3.hready !== 1'b1) begin errors++; $display("FAIL ws_after_hready: got %b want 1", bus3.hready); end
        checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("FAIL ws_after_hrdata: got %h want 0", bus3.hrdata); end
    endtask

    task automatic test_error();
        logic [9:0] bad_a [3];
        logic [2:0] bad_s [3];
        bad_a[0] = 10'h100; bad_s[0] = 3'd2;   // index 64
        bad_a[1] = 10'h002; bad_s[1] = 3'd2;   // misaligned word
        bad_a[2] = 10'h000; bad_s[2] = 3'd3;   // wider than the bus
        write0(10'h000, 32'h01234567);
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk); addr0(1'b1, T_NS, 1'b1, bad_s[k], bad_a[k]); bus0.hwdata = 32'h0;
            @(negedge hclk);
            checks++; if (bus0.hready !== 1'b0 || bus0.hresp !== 1'b1) begin
                errors++; $display("FAIL err%0d_cycle1: hready/hresp=%b%b want 01", k, bus0.hready, bus0.hresp); end
            addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = 32'hFFFFFFFF;
            @(negedge hclk);
            checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b1) begin
                errors++; $display("FAIL err%0d_cycle2: hready/hresp=%b%b want 11", k, bus0.hready, bus0.hresp); end
            // New address phase accepted on the ERR2 edge.
            addr0(1'b1, T_NS, 1'b0, 3'd2, 10'h000);
            exp_q.push_back(32'h01234567);
            @(negedge hclk);
            exp_w = exp_q.pop_front();
            checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b0) begin
                errors++; $display("FAIL err%0d_after: hready/hresp=%b%b want 10", k, bus0.hready, bus0.hresp); end
            checks++; if (bus0.hrdata !== exp_w) begin
                errors++; $display("FAIL err%0d_mem: got %h want %h", k, bus0.hrdata, exp_w); end
            addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = 32'h0;
        end
        // Error timing does not depend on wait states.
        @(negedge hclk); addr3(1'b1, T_NS, 1'b1, 3'd2, 10'h100);
        @(negedge hclk);
        checks++; if (bus3.hready !== 1'b0 || bus3.hresp !== 1'b1) begin
            errors++; $display("FAIL err_ws_cycle1: hready/hresp=%b%b want 01", bus3.hready, bus3.hresp); end
        addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000);
        @(negedge hclk);
        checks++; if (bus3.hready !== 1'b1 || bus3.hresp !== 1'b1) begin
            errors++; $display("FAIL err_ws_cycle2: hready/hresp=%b%b want 11", bus3.hready, bus3.hresp); end
        @(negedge hclk);
        checks++; if (bus3.hready !== 1'b1 || bus3.hresp !== 1'b0) begin
            errors++; $display("FAIL err_ws_idle: hready/hresp=%b%b want 10", bus3.hready, bus3.hresp); end
    endtask

    task automatic test_busy_unselected();
        write0(10'h030, 32'h55AA55AA);
        @(negedge hclk); addr0(1'b0, T_SEQ, 1'b1, 3'd2, 10'h030); bus0.hwdata = 32'h0;
        @(negedge hclk);
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL unsel_hready: got %b want 1", bus0.hready); end
        addr0(1'b1, T_BUSY, 1'b1, 3'd2, 10'h030); bus0.hwdata = 32'h0;
        @(negedge hclk);
        checks++; if (bus0.hready !== 1'b1) begin errors++; $display("FAIL busy_hready: got %b want 1", bus0.hready); end
        addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus0.hwdata = 32'h0;
        @(negedge hclk);
        checks++; if (bus0.hready !== 1'b1 || bus0.hresp !== 1'b0) begin
            errors++; $display("FAIL busy_after: hready/hresp=%b%b want 10", bus0.hready, bus0.hresp); end
        addr0(1'b1, T_NS, 1'b0, 3'd2, 10'h030);
        exp_q.push_back(32'h55AA55AA);
        @(negedge hclk);
        exp_w = exp_q.pop_front();
        checks++; if (bus0.hrdata !== exp_w) begin errors++; $display("FAIL busy_mem: got %h want %h", bus0.hrdata, exp_w); end
        addr0(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000);
    endtask

    task automatic test_mid_reset();
        int lows;
        write3(10'h040, 32'h11111111);
        @(negedge hclk); addr3(1'b1, T_NS, 1'b1, 3'd2, 10'h040);
        @(negedge hclk); addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000); bus3.hwdata = 32'h22222222;
        checks++; if (bus3.hready !== 1'b0) begin errors++; $display("FAIL mrst_wait: got %b want 0", bus3.hready); end
        @(negedge hclk);
        #1 hresetn = 1'b0;
        #1;
        checks++; if (bus3.hready !== 1'b1 || bus3.hresp !== 1'b0 || bus3.hrdata !== 32'h0) begin
            errors++; $display("FAIL mrst_outputs: hready=%b hresp=%b hrdata=%h want 1 0 0",
                               bus3.hready, bus3.hresp, bus3.hrdata); end
        repeat (2) @(negedge hclk);
        hresetn = 1'b1; bus3.hwdata = 32'h0;
        @(negedge hclk); addr3(1'b1, T_NS, 1'b0, 3'd2, 10'h040);
        exp_q.push_back(32'h11111111);
        @(negedge hclk); addr3(1'b0, T_IDLE, 1'b0, 3'd2, 10'h000);
        lows = 0;
        while (bus3.hready !== 1'b1 && lows < 20) begin lows++; @(negedge hclk); end
        exp_w = exp_q.pop_front();
        checks++; if (lows != 3) begin errors++; $display("FAIL mrst_read_waits: got %0d want 3", lows); end
        checks++; if (bus3.hrdata !== exp_w) begin errors++; $display("FAIL mrst_mem: got %h want %h", bus3.hrdata, exp_w); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_busy_unselected();
        test_mid_reset();
        repeat (2) @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
